// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared widths, IO window base, state and owner encodings and
//               the length-decode helper used by the memory controller.
// Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int          c_ADDR_SIZE = 32;
    localparam int          c_INST_SIZE = 32;
    localparam logic        c_TRUE      = 1'b1;
    localparam logic        c_FALSE     = 1'b0;
    localparam logic [31:0] c_IO_BASE   = 32'h0003_0000;

    // Controller states
    localparam logic [1:0]  c_MC_IDLE   = 2'd0;
    localparam logic [1:0]  c_MC_RD     = 2'd1;
    localparam logic [1:0]  c_MC_WR     = 2'd2;
    localparam logic [1:0]  c_MC_DONE   = 2'd3;

    // Owner of the current transfer
    localparam logic        c_MC_OWN_IF = 1'b0;
    localparam logic        c_MC_OWN_LS = 1'b1;

    // Only 1, 2 and 4 byte transfers exist; anything else becomes a word.
    function automatic logic [2:0] mc_len_decode(input logic [2:0] len);
        case (len)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Owner of the byte-wide RAM/IO port. Round-robin arbitration
//               between instruction refill and the load/store buffer, split
//               into byte transfers, with flush, stall and IO backpressure.
// Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = c_ADDR_SIZE,
    parameter logic [ADDR_W-1:0] IO_BASE = c_IO_BASE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clr,
    input  logic                   IF_req,
    input  logic [ADDR_W-1:0]      IF_addr,
    output logic                   IF_done,
    output logic [c_INST_SIZE-1:0] IF_inst,
    input  logic                   LS_req,
    input  logic                   LS_wr,
    input  logic [ADDR_W-1:0]      LS_addr,
    input  logic [2:0]             LS_len,
    input  logic [31:0]            LS_wdata,
    output logic                   LS_done,
    output logic [31:0]            LS_rdata,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [ADDR_W-1:0]      mem_a,
    output logic                   mem_wr,
    input  logic                   io_buffer_full
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_owner;
    logic              r_is_wr;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_ls_rdata;

    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_grant;
    logic              w_io_stall;
    logic [1:0]        w_lane;
    logic [31:0]       w_buf_nxt;

    // Round-robin grant: on a tie the requester that did not win last time wins.
    assign w_grant_ls = (r_state == c_MC_IDLE) && !clr && LS_req &&
                        (!IF_req || (r_last_grant == c_MC_OWN_IF));
    assign w_grant_if = (r_state == c_MC_IDLE) && !clr && IF_req && !w_grant_ls;
    assign w_grant    = w_grant_if || w_grant_ls;

    // IO sink backpressure only matters for stores into the IO window.
    assign w_io_stall = (r_base >= IO_BASE) && io_buffer_full;

    // Merge the byte arriving on mem_din into the lane it belongs to (counter lags by one).
    always_comb begin
        w_lane    = r_cnt[1:0] - 2'd1;
        w_buf_nxt = r_buf;
        w_buf_nxt[{w_lane, 3'b000} +: 8] = mem_din;
    end

    // State register; a low rdy freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_MC_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_MC_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = (w_grant_ls && LS_wr) ? c_MC_WR : c_MC_RD;
                end
            end
            c_MC_RD: begin
                if (clr) begin
                    w_state_nxt = c_MC_IDLE;
                end else if (r_cnt == r_len) begin
                    w_state_nxt = c_MC_DONE;
                end
            end
            c_MC_WR: begin
                if (!w_io_stall && ((r_cnt + 3'd1) == r_len)) begin
                    w_state_nxt = c_MC_DONE;
                end
            end
            default: w_state_nxt = c_MC_IDLE;
        endcase
    end

    // Transfer context, byte counter, read assembly and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= c_MC_OWN_IF;
            r_is_wr      <= 1'b0;
            r_last_grant <= c_MC_OWN_IF;
            r_base       <= '0;
            r_len        <= 3'd0;
            r_cnt        <= 3'd0;
            r_wdata      <= 32'd0;
            r_buf        <= 32'd0;
            r_if_inst    <= 32'd0;
            r_ls_rdata   <= 32'd0;
        end else if (rdy) begin
            case (r_state)
                c_MC_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_grant_ls ? c_MC_OWN_LS : c_MC_OWN_IF;
                        r_last_grant <= w_grant_ls ? c_MC_OWN_LS : c_MC_OWN_IF;
                        r_is_wr      <= w_grant_ls && LS_wr;
                        r_base       <= w_grant_ls ? LS_addr : IF_addr;
                        r_len        <= w_grant_ls ? mc_len_decode(LS_len) : 3'd4;
                        r_wdata      <= LS_wdata;
                        r_cnt        <= 3'd0;
                        r_buf        <= 32'd0;
                    end
                end
                c_MC_RD: begin
                    // A flush drops the partial word; r_buf is cleared on the next grant.
                    if (!clr) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt != 3'd0) begin
                            r_buf <= w_buf_nxt;
                        end
                        if (r_cnt == r_len) begin
                            if (r_owner == c_MC_OWN_IF) begin
                                r_if_inst <= w_buf_nxt;
                            end else begin
                                r_ls_rdata <= w_buf_nxt;
                            end
                        end
                    end
                end
                c_MC_WR: begin
                    if (!w_io_stall) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_cnt <= 3'd0;
            endcase
        end
    end

    // Port drive and done pulses; bus is idle (all zero) outside active cycles.
    always_comb begin
        mem_a    = '0;
        mem_wr   = c_FALSE;
        mem_dout = 8'd0;
        IF_done  = c_FALSE;
        LS_done  = c_FALSE;
        case (r_state)
            c_MC_RD: begin
                if (r_cnt < r_len) begin
                    mem_a = r_base + ADDR_W'(r_cnt);
                end
            end
            c_MC_WR: begin
                mem_a    = r_base + ADDR_W'(r_cnt);
                mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                mem_wr   = rdy && !w_io_stall;
            end
            c_MC_DONE: begin
                if (r_owner == c_MC_OWN_IF) begin
                    IF_done = !clr;
                end else begin
                    LS_done = r_is_wr || !clr;
                end
            end
            default: ;
        endcase
    end

    assign IF_inst  = r_if_inst;
    assign LS_rdata = r_ls_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a byte RAM
//               model and queues of expected completions and bus writes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        IF_req;
    logic [31:0] IF_addr;
    logic        IF_done;
    logic [31:0] IF_inst;
    logic        LS_req;
    logic        LS_wr;
    logic [31:0] LS_addr;
    logic [2:0]  LS_len;
    logic [31:0] LS_wdata;
    logic        LS_done;
    logic [31:0] LS_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    typedef struct {
        logic        is_if;
        logic        chk_data;
        logic [31:0] data;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    done_t exp_done[$];
    wr_t   exp_wr[$];
    done_t mon_d;
    wr_t   mon_w;

    logic [7:0] ram [0:4095];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .IF_req(IF_req), .IF_addr(IF_addr), .IF_done(IF_done), .IF_inst(IF_inst),
        .LS_req(LS_req), .LS_wr(LS_wr), .LS_addr(LS_addr), .LS_len(LS_len),
        .LS_wdata(LS_wdata), .LS_done(LS_done), .LS_rdata(LS_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: one-cycle registered read, stalls together with the controller.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'(i) ^ 8'hA5;
            ram[256] <= 8'h13;
            ram[257] <= 8'h00;
            ram[258] <= 8'h00;
            ram[259] <= 8'h00;
            mem_din  <= 8'h00;
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ai;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            r[8*i +: 8] = ram[ai[11:0]];
        end
        return r;
    endfunction

    task automatic push_done(input logic is_if, input logic chk_data, input logic [31:0] data);
        done_t d;
        d.is_if = is_if; d.chk_data = chk_data; d.data = data;
        exp_done.push_back(d);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: every completion and every bus write is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (IF_done || LS_done) begin
                chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) begin
                    mon_d = exp_done.pop_front();
                    chk("done_if_flag", 32'(IF_done), 32'(mon_d.is_if));
                    chk("done_ls_flag", 32'(LS_done), 32'(!mon_d.is_if));
                    if (mon_d.chk_data)
                        chk("done_data", mon_d.is_if ? IF_inst : LS_rdata, mon_d.data);
                end
            end
            if (mem_wr) begin
                chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_addr", mem_a, mon_w.addr);
                    chk("wr_data", 32'(mem_dout), 32'(mon_w.data));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        IF_req = 1'b0; IF_addr = 32'd0;
        LS_req = 1'b0; LS_wr = 1'b0; LS_addr = 32'd0; LS_len = 3'd0; LS_wdata = 32'd0;
        io_buffer_full = 1'b0;
        repeat (3) adv();
        smp();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_done", 32'(IF_done), 32'd0);
        chk("rst_ls_done", 32'(LS_done), 32'd0);
        chk("rst_if_inst", IF_inst, 32'd0);
        chk("rst_ls_rdata", LS_rdata, 32'd0);
        adv(); rst = 1'b0;
        adv();

        // Instruction refill from 0x100
        IF_req = 1'b1; IF_addr = 32'h100;
        push_done(1'b1, 1'b1, 32'h0000_0013);
        for (int c = 1; c <= 6; c++) begin
            adv(); smp();
            if (c <= 4) chk("fetch_mem_a", mem_a, 32'h100 + 32'(c - 1));
            if (c == 5) chk("fetch_idle_a", mem_a, 32'd0);
            chk("fetch_if_done", 32'(IF_done), 32'(c == 6));
        end
        chk("fetch_if_inst", IF_inst, 32'h0000_0013);
        adv(); IF_req = 1'b0;

        // Two-byte store to 0x200
        adv();
        LS_req = 1'b1; LS_wr = 1'b1; LS_addr = 32'h200; LS_len = 3'd2; LS_wdata = 32'h0000_ABCD;
        push_wr(32'h200, 8'hCD); push_wr(32'h201, 8'hAB);
        push_done(1'b0, 1'b0, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            adv(); smp();
            chk("st_mem_wr", 32'(mem_wr), 32'(c <= 2));
            if (c <= 2) begin
                chk("st_mem_a", mem_a, 32'h200 + 32'(c - 1));
                chk("st_mem_dout", 32'(mem_dout), (c == 1) ? 32'hCD : 32'hAB);
            end
            chk("st_ls_done", 32'(LS_done), 32'(c == 3));
        end
        adv(); LS_req = 1'b0; LS_wr = 1'b0;

        // Simultaneous requests after reset: LS, then IF, then LS again
        adv(); rst = 1'b1;
        adv(); rst = 1'b0;
        IF_req = 1'b1; IF_addr = 32'h104;
        LS_req = 1'b1; LS_wr = 1'b0; LS_addr = 32'h300; LS_len = 3'd4;
        push_done(1'b0, 1'b1, exp_word(32'h300, 4));
        push_done(1'b1, 1'b1, exp_word(32'h104, 4));
        push_done(1'b0, 1'b1, exp_word(32'h304, 4));
        for (int c = 1; c <= 20; c++) begin
            adv();
            if (c == 7)  LS_addr = 32'h304;
            if (c == 14) IF_req = 1'b0;
            smp();
            if (c == 1)  chk("arb_ls_first", mem_a, 32'h300);
            if (c == 6)  chk("arb_ls_done", 32'(LS_done), 32'd1);
            if (c == 8)  chk("arb_if_second", mem_a, 32'h104);
            if (c == 13) chk("arb_if_done", 32'(IF_done), 32'd1);
            if (c == 15) chk("arb_ls_third", mem_a, 32'h304);
            if (c == 20) chk("arb_ls_done2", 32'(LS_done), 32'd1);
        end
        adv(); LS_req = 1'b0;

        // Flush during a refill while a load waits
        adv();
        IF_req = 1'b1; IF_addr = 32'h108;
        LS_req = 1'b1; LS_wr = 1'b0; LS_addr = 32'h20C; LS_len = 3'd1;
        push_done(1'b0, 1'b1, exp_word(32'h20C, 1));
        for (int c = 1; c <= 7; c++) begin
            adv();
            if (c == 3) clr = 1'b1;
            if (c == 4) begin clr = 1'b0; IF_req = 1'b0; end
            smp();
            if (c == 3) chk("clr_mem_a_c3", mem_a, 32'h10A);
            if (c == 4) chk("clr_mem_a_c4", mem_a, 32'd0);
            if (c == 5) chk("clr_ls_grant", mem_a, 32'h20C);
            chk("clr_no_if_done", 32'(IF_done), 32'd0);
            chk("clr_ls_done", 32'(LS_done), 32'(c == 7));
        end
        adv(); LS_req = 1'b0;

        // IO store held off by a full output buffer
        adv();
        io_buffer_full = 1'b1;
        LS_req = 1'b1; LS_wr = 1'b1; LS_addr = 32'h0003_0000; LS_len = 3'd1; LS_wdata = 32'h0000_005E;
        push_wr(32'h0003_0000, 8'h5E);
        push_done(1'b0, 1'b0, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            adv();
            if (c == 4) io_buffer_full = 1'b0;
            smp();
            chk("io_mem_wr", 32'(mem_wr), 32'(c == 4));
            if (c == 4) chk("io_mem_dout", 32'(mem_dout), 32'h5E);
            chk("io_ls_done", 32'(LS_done), 32'(c == 5));
        end
        adv(); LS_req = 1'b0;

        // Store just below the IO window ignores full; rdy low suppresses the strobe
        adv();
        io_buffer_full = 1'b1;
        LS_req = 1'b1; LS_wr = 1'b1; LS_addr = 32'h0002_FFFF; LS_len = 3'd1; LS_wdata = 32'h0000_0077;
        push_wr(32'h0002_FFFF, 8'h77);
        push_done(1'b0, 1'b0, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            adv();
            if (c == 1) rdy = 1'b0;
            if (c == 2) rdy = 1'b1;
            smp();
            if (c == 1) chk("ram_stall_mem_a", mem_a, 32'h0002_FFFF);
            chk("ram_mem_wr", 32'(mem_wr), 32'(c == 2));
            chk("ram_ls_done", 32'(LS_done), 32'(c == 3));
        end
        adv(); LS_req = 1'b0; LS_wr = 1'b0; io_buffer_full = 1'b0;

        // Four-byte load with a two-cycle stall in the middle
        adv();
        LS_req = 1'b1; LS_wr = 1'b0; LS_addr = 32'h310; LS_len = 3'd4;
        push_done(1'b0, 1'b1, exp_word(32'h310, 4));
        for (int c = 1; c <= 8; c++) begin
            adv();
            if (c == 3) rdy = 1'b0;
            if (c == 5) rdy = 1'b1;
            smp();
            if (c >= 3 && c <= 5) chk("stall_mem_a", mem_a, 32'h312);
            if (c == 3 || c == 4) chk("stall_mem_wr", 32'(mem_wr), 32'd0);
            chk("stall_ls_done", 32'(LS_done), 32'(c == 8));
        end
        adv(); LS_req = 1'b0;

        // Illegal length 3 behaves as a word
        adv();
        LS_req = 1'b1; LS_addr = 32'h320; LS_len = 3'd3;
        push_done(1'b0, 1'b1, exp_word(32'h320, 4));
        for (int c = 1; c <= 6; c++) begin
            adv(); smp();
            if (c == 4) chk("len3_mem_a", mem_a, 32'h323);
            chk("len3_ls_done", 32'(LS_done), 32'(c == 6));
        end
        adv(); LS_req = 1'b0;

        // Halfword load wrapping the top of the address space
        adv();
        LS_req = 1'b1; LS_addr = 32'hFFFF_FFFF; LS_len = 3'd2;
        push_done(1'b0, 1'b1, exp_word(32'hFFFF_FFFF, 2));
        for (int c = 1; c <= 4; c++) begin
            adv(); smp();
            if (c == 1) chk("wrap_mem_a0", mem_a, 32'hFFFF_FFFF);
            if (c == 2) chk("wrap_mem_a1", mem_a, 32'd0);
            chk("wrap_ls_done", 32'(LS_done), 32'(c == 4));
        end
        adv(); LS_req = 1'b0;

        repeat (4) adv();
        smp();
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

        if (n_fail != 0) $display("%0d comparison(s) did not hold", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
